cru_master: RTL and testbench
=============================

CRU_MASTER -- requirements
Module: cru_master

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles that address and data are held before each strobe or sample; legal range 1..15.
REQ-002 Parameter STROBE_CYC, default 2: width of each ti_cru_clk pulse, and the wait before each ti_cru_in sample, in clk cycles; legal range 1..15.
REQ-003 Port clk  input  1: the only clock; all state changes on the rising edge.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port start  input  1: one-cycle command request.
REQ-006 Port op  input  [0:1]: command code; 00 SBO, 01 SBZ, 10 LDCR, 11 STCR.
REQ-007 Port cru_addr  input  [0:11]: CRU bit address of the first bit.
REQ-008 Port count  input  [0:3]: LDCR/STCR bit count; 0 means 16; ignored for SBO/SBZ.
REQ-009 Port wdata  input  [0:15]: LDCR source data; the transfer LSB is wdata[15].
REQ-010 Port rdata  output  [0:15]: STCR result.
REQ-011 Port busy  output  1: command in progress.
REQ-012 Port done  output  1: one-cycle completion pulse.
REQ-013 Port ti_addr  output  [0:14]: bus address; ti_addr[0:2] always 0; ti_addr[3:14] carries the current bit address.
REQ-014 Port ti_memen  output  1: high when no memory cycle is in progress; held high throughout operation.
REQ-015 Port ti_cru_out  output  1: CRU write data.
REQ-016 Port ti_cru_clk  output  1: active-high CRU write strobe.
REQ-017 Port ti_ph3  output  1: phase strobe; high exactly while ti_cru_clk is high.
REQ-018 Port ti_cru_in  input  1: CRU read data from the responder.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, STROBE, SAMPLE, HOLD, DONE.
REQ-020 In IDLE, start SHALL latch op, cru_addr, the effective count (1 for SBO/SBZ, 16 when count=0) and wdata, SHALL set busy on the next edge, and SHALL enter SETUP.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 Bit k (k = 0..N-1) SHALL use address (cru_addr + k) mod 4096; addresses wrap from 0xFFF to 0x000.
REQ-023 SETUP SHALL drive ti_addr and, for write ops, ti_cru_out, and SHALL last SETUP_CYC cycles.
REQ-024 ti_cru_out SHALL be 1 for SBO, 0 for SBZ, and wdata[15-k] for LDCR.
REQ-025 For write ops, SETUP SHALL go to STROBE: ti_cru_clk=1 and ti_ph3=1 for STROBE_CYC cycles, then HOLD.
REQ-026 For STCR, SETUP SHALL go to SAMPLE, lasting STROBE_CYC cycles, and ti_cru_in SHALL be captured into rdata[15-k] on the last SAMPLE edge.
REQ-027 HOLD SHALL last 1 cycle with ti_cru_clk=0 and address/data unchanged.
REQ-028 After HOLD, the FSM SHALL go to SETUP for bit k+1 if k+1 < N, otherwise to DONE.
REQ-029 In DONE, done=1 and busy=0 for one cycle; the FSM then returns to IDLE.
REQ-030 A start asserted during DONE SHALL be accepted identically to one asserted in IDLE.
REQ-031 STCR SHALL clear rdata to 0 at command acceptance, so bits above N-1 read 0.
REQ-032 LDCR, SBO and SBZ SHALL leave rdata unchanged.
REQ-033 Per-bit latency SHALL be SETUP_CYC + STROBE_CYC + 1 cycles; done SHALL rise N*(SETUP_CYC+STROBE_CYC+1)+1 cycles after the start edge.
REQ-034 ti_cru_clk SHALL be glitch-free: it is registered, and never high in the same cycle that ti_addr or ti_cru_out changes.

Reset
REQ-035 reset_n low SHALL immediately (asynchronously) force IDLE, busy=0, done=0, rdata=0, ti_addr=0, ti_cru_out=0, ti_cru_clk=0, ti_ph3=0, ti_memen=1.
REQ-036 Reset asserted mid-command SHALL abort with no further strobes; the first start after release SHALL begin a fresh command.

Verification
REQ-037 SBO, cru_addr=0x880 (defaults) -> exactly one ti_cru_clk pulse 2 cycles wide, with ti_addr[3:14]=0x880 and ti_cru_out=1; done 5 cycles after start.
REQ-038 LDCR, count=4, wdata=0x000A, cru_addr=0x880 -> ti_cru_out sequence 0,1,0,1 at addresses 0x880..0x883; done at cycle 17.
REQ-039 STCR, count=0, with a responder model returning bit k = k odd -> rdata=0xAAAA after 16 transfers.
REQ-040 STCR, count=3, cru_addr=0xFFF, ti_cru_in=1 -> addresses 0xFFF, 0x000, 0x001 in that order; rdata=0x0007.
REQ-041 start held high throughout an LDCR -> only one command executes; a start in the DONE cycle launches the next command with no gap.
REQ-042 reset_n pulsed low during bit 2 of an LDCR with count=8 -> ti_cru_clk drops immediately, busy=0, no done pulse.

Source files
------------

// File: rtl/cru_master.sv
// CRU bus master: runs SBO/SBZ/LDCR/STCR as serial bit transfers on the TI CRU interface.
// Every bit goes through SETUP, then STROBE (writes) or SAMPLE (STCR), then a one-cycle HOLD.
module cru_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [0:1]  op,
  input  logic [0:11] cru_addr,
  input  logic [0:3]  count,
  input  logic [0:15] wdata,
  output logic [0:15] rdata,
  output logic        busy,
  output logic        done,
  output logic [0:14] ti_addr,
  output logic        ti_memen,
  output logic        ti_cru_out,
  output logic        ti_cru_clk,
  output logic        ti_ph3,
  input  logic        ti_cru_in
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StSample,
    StHold,
    StDone
  } state_e;

  localparam logic [1:0] OpSbo  = 2'b00;
  localparam logic [1:0] OpSbz  = 2'b01;
  localparam logic [1:0] OpLdcr = 2'b10;
  localparam logic [1:0] OpStcr = 2'b11;

  localparam logic [3:0] SetupLast  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] StrobeLast = 4'(STROBE_CYC - 1);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [4:0]  n_q, n_d;
  logic [4:0]  k_q, k_d;
  logic [3:0]  cyc_q, cyc_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cru_out_q, cru_out_d;
  logic        cru_clk_q, cru_clk_d;

  logic        accept;
  logic [1:0]  op_in;
  logic [15:0] wdata_in;

  assign op_in    = op;
  assign wdata_in = wdata;

  // Write-data value for one bit; STCR drives 0.
  function automatic logic out_bit(input logic [1:0] o, input logic b);
    logic r;
    r = 1'b0;
    unique case (o)
      OpSbo:   r = 1'b1;
      OpSbz:   r = 1'b0;
      OpLdcr:  r = b;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    n_d       = n_q;
    k_d       = k_q;
    cyc_d     = cyc_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    cru_out_d = cru_out_q;
    accept    = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) accept = 1'b1;
      end
      StSetup: begin
        if (cyc_q == SetupLast) begin
          cyc_d   = 4'd0;
          state_d = (op_q == OpStcr) ? StSample : StStrobe;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      StStrobe: begin
        if (cyc_q == StrobeLast) begin
          cyc_d   = 4'd0;
          state_d = StHold;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      StSample: begin
        if (cyc_q == StrobeLast) begin
          cyc_d             = 4'd0;
          rdata_d[k_q[3:0]] = ti_cru_in;
          state_d           = StHold;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      StHold: begin
        if ((k_q + 5'd1) < n_q) begin
          k_d       = k_q + 5'd1;
          addr_d    = addr_q + 12'd1;
          shift_d   = shift_q >> 1;
          cru_out_d = out_bit(op_q, shift_d[0]);
          state_d   = StSetup;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (start) accept = 1'b1;
        else state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      op_d      = op_in;
      addr_d    = cru_addr;
      k_d       = 5'd0;
      cyc_d     = 4'd0;
      shift_d   = wdata_in;
      cru_out_d = out_bit(op_in, wdata_in[0]);
      if (op_in == OpSbo || op_in == OpSbz) n_d = 5'd1;
      else if (count == 4'd0)               n_d = 5'd16;
      else                                  n_d = {1'b0, count};
      if (op_in == OpStcr) rdata_d = 16'h0000;
      state_d = StSetup;
    end

    // Strobe is registered from the next state so it never overlaps an address/data change.
    cru_clk_d = (state_d == StStrobe);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      op_q      <= 2'b00;
      addr_q    <= 12'h000;
      n_q       <= 5'd0;
      k_q       <= 5'd0;
      cyc_q     <= 4'd0;
      shift_q   <= 16'h0000;
      rdata_q   <= 16'h0000;
      cru_out_q <= 1'b0;
      cru_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      n_q       <= n_d;
      k_q       <= k_d;
      cyc_q     <= cyc_d;
      shift_q   <= shift_d;
      rdata_q   <= rdata_d;
      cru_out_q <= cru_out_d;
      cru_clk_q <= cru_clk_d;
    end
  end

  assign busy       = (state_q == StSetup) || (state_q == StStrobe) ||
                      (state_q == StSample) || (state_q == StHold);
  assign rdata      = rdata_q;
  assign ti_addr    = {3'b000, addr_q};
  assign ti_memen   = 1'b1;
  assign ti_cru_out = cru_out_q;
  assign ti_cru_clk = cru_clk_q;
  assign ti_ph3     = cru_clk_q;

endmodule

// File: tb/tb_cru_master.sv
// Directed bench for cru_master with default timing (4 cycles per bit).
module tb_cru_master;
  localparam int PB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [0:1]  op = 2'b00;
  logic [0:11] cru_addr = 12'h000;
  logic [0:3]  count = 4'h0;
  logic [0:15] wdata = 16'h0000;
  logic [0:15] rdata;
  logic        busy, done, ti_memen, ti_cru_out, ti_cru_clk, ti_ph3, ti_cru_in;
  logic [0:14] ti_addr;
  logic        resp_mode = 1'b0;
  logic        resp_const = 1'b0;

  assign ti_cru_in = resp_mode ? ti_addr[14] : resp_const;

  cru_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op         (op),
    .cru_addr   (cru_addr),
    .count      (count),
    .wdata      (wdata),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .ti_addr    (ti_addr),
    .ti_memen   (ti_memen),
    .ti_cru_out (ti_cru_out),
    .ti_cru_clk (ti_cru_clk),
    .ti_ph3     (ti_ph3),
    .ti_cru_in  (ti_cru_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int          npulse, done_cyc, glitches, ph3_bad;
  logic        busy1;
  logic [11:0] pulse_addr [16];
  logic        pulse_dout [16];
  int          pulse_w    [16];
  logic [11:0] addr_at    [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Call just after a rising edge; that edge is cycle 0 of the command.
  task automatic run_cmd(input logic [1:0] o, input logic [11:0] a, input logic [3:0] c,
                         input logic [15:0] w, input bit keep, input int max_c);
    logic [0:14] prev_addr;
    logic        prev_out, prev_clk;
    op = o; cru_addr = a; count = c; wdata = w; start = 1'b1;
    npulse = 0; done_cyc = 0; glitches = 0; ph3_bad = 0; busy1 = 1'b0;
    prev_addr = ti_addr; prev_out = ti_cru_out; prev_clk = ti_cru_clk;
    for (int cy = 1; cy <= max_c && done_cyc == 0; cy++) begin
      @(posedge clk);
      #1;
      if (!keep) start = 1'b0;
      if (cy == 1) busy1 = busy;
      if ((cy - 1) % PB == 0 && (cy - 1) / PB < 16) addr_at[(cy - 1) / PB] = ti_addr[3:14];
      if (ti_cru_clk !== ti_ph3) ph3_bad++;
      if (ti_cru_clk && (ti_addr !== prev_addr || ti_cru_out !== prev_out)) glitches++;
      if (ti_cru_clk && !prev_clk) begin
        if (npulse < 16) begin
          pulse_addr[npulse] = ti_addr[3:14];
          pulse_dout[npulse] = ti_cru_out;
          pulse_w[npulse]    = 1;
        end
        npulse++;
      end else if (ti_cru_clk && prev_clk && npulse > 0 && npulse <= 16) begin
        pulse_w[npulse - 1]++;
      end
      prev_addr = ti_addr; prev_out = ti_cru_out; prev_clk = ti_cru_clk;
      if (done) done_cyc = cy;
    end
  endtask

  initial begin
    int cnt_pulse, cnt_done;
    logic [15:0] wv;

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_addr", 32'(ti_addr), 32'h0);
    check("rst_out", 32'(ti_cru_out), 32'd0);
    check("rst_clk", 32'(ti_cru_clk), 32'd0);
    check("rst_ph3", 32'(ti_ph3), 32'd0);
    check("rst_memen", 32'(ti_memen), 32'd1);
    idle(2);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // SBO at 0x880
    run_cmd(2'b00, 12'h880, 4'h0, 16'h0000, 1'b0, 20);
    check("sbo_done_cyc", 32'(done_cyc), 32'd5);
    check("sbo_busy1", 32'(busy1), 32'd1);
    check("sbo_npulse", 32'(npulse), 32'd1);
    check("sbo_width", 32'(pulse_w[0]), 32'd2);
    check("sbo_addr", 32'(pulse_addr[0]), 32'h880);
    check("sbo_dout", 32'(pulse_dout[0]), 32'd1);
    check("sbo_glitch", 32'(glitches), 32'd0);
    check("sbo_ph3", 32'(ph3_bad), 32'd0);
    check("sbo_done_busy", 32'(busy), 32'd0);
    check("sbo_rdata", 32'(rdata), 32'h0);
    idle(2);

    // SBZ at 0x123
    run_cmd(2'b01, 12'h123, 4'h5, 16'hFFFF, 1'b0, 20);
    check("sbz_done_cyc", 32'(done_cyc), 32'd5);
    check("sbz_npulse", 32'(npulse), 32'd1);
    check("sbz_addr", 32'(pulse_addr[0]), 32'h123);
    check("sbz_dout", 32'(pulse_dout[0]), 32'd0);
    idle(1);

    // LDCR count=4, wdata=0x000A -> 0,1,0,1 at 0x880..0x883
    run_cmd(2'b10, 12'h880, 4'h4, 16'h000A, 1'b0, 40);
    check("ldcr_done_cyc", 32'(done_cyc), 32'd17);
    check("ldcr_npulse", 32'(npulse), 32'd4);
    wv = 16'h000A;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ldcr_addr%0d", k), 32'(pulse_addr[k]), 32'h880 + 32'(k));
      check($sformatf("ldcr_dout%0d", k), 32'(pulse_dout[k]), 32'(wv[k]));
      check($sformatf("ldcr_w%0d", k), 32'(pulse_w[k]), 32'd2);
    end
    check("ldcr_glitch", 32'(glitches), 32'd0);
    idle(2);

    // STCR count=0 (16 bits), responder returns address LSB -> odd bits set
    resp_mode = 1'b1;
    run_cmd(2'b11, 12'h000, 4'h0, 16'h0000, 1'b0, 100);
    check("stcr16_done_cyc", 32'(done_cyc), 32'd65);
    check("stcr16_npulse", 32'(npulse), 32'd0);
    check("stcr16_rdata", 32'(rdata), 32'hAAAA);
    check("stcr16_addr15", 32'(addr_at[15]), 32'h00F);
    resp_mode = 1'b0;
    idle(1);

    // STCR count=3 at 0xFFF wraps to 0x000, 0x001
    resp_const = 1'b1;
    run_cmd(2'b11, 12'hFFF, 4'h3, 16'h0000, 1'b0, 30);
    check("stcr3_done_cyc", 32'(done_cyc), 32'd13);
    check("stcr3_addr0", 32'(addr_at[0]), 32'hFFF);
    check("stcr3_addr1", 32'(addr_at[1]), 32'h000);
    check("stcr3_addr2", 32'(addr_at[2]), 32'h001);
    check("stcr3_rdata", 32'(rdata), 32'h0007);
    resp_const = 1'b0;
    idle(1);

    // start held high for a whole LDCR, then a start in DONE chains the next one
    run_cmd(2'b10, 12'h040, 4'h2, 16'h0002, 1'b1, 30);
    check("hold_done_cyc", 32'(done_cyc), 32'd9);
    check("hold_npulse", 32'(npulse), 32'd2);
    check("hold_dout0", 32'(pulse_dout[0]), 32'd0);
    check("hold_dout1", 32'(pulse_dout[1]), 32'd1);
    run_cmd(2'b10, 12'h010, 4'h1, 16'h0001, 1'b0, 30);
    check("chain_busy1", 32'(busy1), 32'd1);
    check("chain_done_cyc", 32'(done_cyc), 32'd5);
    check("chain_addr", 32'(pulse_addr[0]), 32'h010);
    check("chain_dout", 32'(pulse_dout[0]), 32'd1);
    check("ldcr_keeps_rdata", 32'(rdata), 32'h0007);
    idle(2);

    // Reset during bit 2 strobe of an LDCR count=8
    op = 2'b10; cru_addr = 12'h880; count = 4'h8; wdata = 16'h00FF; start = 1'b1;
    for (int cy = 1; cy <= 10; cy++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("abort_pre_clk", 32'(ti_cru_clk), 32'd1);
    check("abort_pre_addr", 32'(ti_addr[3:14]), 32'h882);
    #2 reset_n = 1'b0;
    #1;
    check("abort_clk", 32'(ti_cru_clk), 32'd0);
    check("abort_ph3", 32'(ti_ph3), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(ti_addr), 32'h0);
    check("abort_rdata", 32'(rdata), 32'h0);
    idle(2);
    @(negedge clk) reset_n = 1'b1;
    cnt_pulse = 0;
    cnt_done = 0;
    for (int cy = 0; cy < 40; cy++) begin
      @(posedge clk);
      #1;
      if (ti_cru_clk) cnt_pulse++;
      if (done) cnt_done++;
    end
    check("abort_no_strobe", 32'(cnt_pulse), 32'd0);
    check("abort_no_done", 32'(cnt_done), 32'd0);
    run_cmd(2'b00, 12'h055, 4'h0, 16'h0000, 1'b0, 20);
    check("post_rst_done_cyc", 32'(done_cyc), 32'd5);
    check("post_rst_addr", 32'(pulse_addr[0]), 32'h055);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
